// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and the RGB332 field widths
// used by the colour stage downstream.
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Counters are 10 bits wide, so neither axis may exceed 1024 positions.
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned MAX_TOTAL = 1024;

    localparam int unsigned RGB_R_W = 3;
    localparam int unsigned RGB_G_W = 3;
    localparam int unsigned RGB_B_W = 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   cmp_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus look-ahead active/sync
// decodes of the value it will hold after the next clock.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL_DEF,
    parameter int unsigned ACTIVE     = H_ACTIVE_DEF,
    parameter int unsigned SYNC_START = H_ACTIVE_DEF + H_FP_DEF,
    parameter int unsigned SYNC_END   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF,
    parameter bit          POL        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    output cnt_t cnt,
    output cnt_t cnt_next,
    output logic wrap,
    output logic active_next,
    output logic sync_next
);

    localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
    localparam cmp_t ACT_C   = cmp_t'(ACTIVE);
    localparam cmp_t SSTRT_C = cmp_t'(SYNC_START);
    localparam cmp_t SEND_C  = cmp_t'(SYNC_END);

    cnt_t cnt_q;
    cnt_t cnt_d;
    cmp_t cnt_ext;

    always_comb begin
        wrap  = step && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (step) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        // One extra bit so a sync end equal to 1024 still compares correctly.
        cnt_ext     = {1'b0, cnt_d};
        active_next = (cnt_ext < ACT_C);
        sync_next   = ((cnt_ext >= SSTRT_C) && (cnt_ext < SEND_C)) ? POL : ~POL;
    end

    // Parked on the last position so the first clock after reset lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign cnt_next = cnt_d;

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: registered coordinates, active qualifier,
// sync pulses, line/frame strobes and a wrapping frame counter.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic       VGA_CLK,
    input  logic       RST_N,
    output logic [9:0] X,
    output logic [9:0] Y,
    output logic       valid,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    cnt_t h_cnt, h_next, v_cnt, v_next;
    logic h_wrap, h_act, h_sync;
    logic v_wrap, v_act, v_sync;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC), .POL(HS_POL)
    ) u_h (
        .clk(VGA_CLK), .rst_n(RST_N), .step(1'b1),
        .cnt(h_cnt), .cnt_next(h_next), .wrap(h_wrap),
        .active_next(h_act), .sync_next(h_sync)
    );

    vga_axis_counter #(
        .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC), .POL(VS_POL)
    ) u_v (
        .clk(VGA_CLK), .rst_n(RST_N), .step(h_wrap),
        .cnt(v_cnt), .cnt_next(v_next), .wrap(v_wrap),
        .active_next(v_act), .sync_next(v_sync)
    );

    logic [9:0] x_q, x_d, y_q, y_d;
    logic       valid_q, valid_d, hs_q, hs_d, vs_q, vs_d;
    logic       ls_q, ls_d, fs_q, fs_d, started_q, started_d;
    logic [7:0] fcnt_q, fcnt_d;

    // Outputs decode the next counter values so the flops line up with h/v.
    always_comb begin
        valid_d   = h_act && v_act;
        x_d       = valid_d ? h_next : '0;
        y_d       = valid_d ? v_next : '0;
        hs_d      = h_sync;
        vs_d      = v_sync;
        ls_d      = (h_cnt == H_LAST);
        fs_d      = h_wrap && (v_cnt == V_LAST);
        started_d = started_q | fs_d;
        fcnt_d    = fcnt_q;
        // The first frame after reset is frame 0; later frame starts count up.
        if (v_wrap && started_q) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            x_q       <= '0;
            y_q       <= '0;
            valid_q   <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            started_q <= 1'b0;
            fcnt_q    <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            valid_q   <= valid_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
            started_q <= started_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign X           = x_q;
    assign Y           = y_q;
    assign valid       = valid_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default 640x480 instance and a reduced-size instance
// (8x4 active, 12x7 total) run side by side from one clock and reset.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] b_x, b_y, s_x, s_y;
    logic       b_v, b_hs, b_vs, b_ls, b_fs;
    logic       s_v, s_hs, s_vs, s_ls, s_fs;
    logic [7:0] b_fc, s_fc;

    vga_sync_gen u_big (
        .VGA_CLK(clk), .RST_N(rst_n), .X(b_x), .Y(b_y), .valid(b_v),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .line_start(b_ls), .frame_start(b_fs),
        .frame_cnt(b_fc)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_sm (
        .VGA_CLK(clk), .RST_N(rst_n), .X(s_x), .Y(s_y), .valid(s_v),
        .VGA_HS(s_hs), .VGA_VS(s_vs), .line_start(s_ls), .frame_start(s_fs),
        .frame_cnt(s_fc)
    );

    wire [32:0] b_act = {b_x, b_y, b_v, b_hs, b_vs, b_ls, b_fs, b_fc};
    wire [32:0] s_act = {s_x, s_y, s_v, s_hs, s_vs, s_ls, s_fs, s_fc};
    localparam logic [32:0] RST_EXP = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] ev(input int x, input int y, input bit v, input bit hs,
                                       input bit vs, input bit ls, input bit fs, input int fc);
        return {10'(x), 10'(y), v, hs, vs, ls, fs, 8'(fc)};
    endfunction

    typedef struct {
        int          cyc;
        logic [32:0] exp;
    } vec_t;

    localparam int NT = 12;
    vec_t tbl[NT];

    // Scoreboard for the small instance: reference model pushes at each edge,
    // the opposite edge pops and compares.
    initial begin : scoreboard
        logic [32:0] q[$];
        logic [32:0] e;
        int  mh, mv, mfc;
        bit  mst, mvld;
        mh = 11; mv = 6; mfc = 0; mst = 0;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                mh = (mh == 11) ? 0 : mh + 1;
                if (mh == 0) mv = (mv == 6) ? 0 : mv + 1;
                if (mh == 0 && mv == 0) begin
                    if (mst) mfc = (mfc + 1) % 256;
                    mst = 1;
                end
                mvld = (mh < 8) && (mv < 4);
                q.push_back(ev(mvld ? mh : 0, mvld ? mv : 0, mvld,
                               !(mh >= 9 && mh < 11), mv != 5,
                               mh == 0, (mh == 0 && mv == 0), mfc));
            end else begin
                mh = 11; mv = 6; mfc = 0; mst = 0;
            end
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                chk("sb_reset", s_act, RST_EXP);
            end else if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_cycle", s_act, e);
            end
        end
    end

    initial begin : main
        int ti, last_ls, b_vcnt, b_hscnt, b_hsfirst, b_fscnt;
        int s_fsn, s_last, s_vcnt, s_vslo, s_hslo, s_maxx, s_maxy, s_bad;
        bit found;
        localparam int N = 84 * 258;

        tbl[0]  = '{0,    ev(0,   0, 1, 1, 1, 1, 1, 0)};
        tbl[1]  = '{1,    ev(1,   0, 1, 1, 1, 0, 0, 0)};
        tbl[2]  = '{639,  ev(639, 0, 1, 1, 1, 0, 0, 0)};
        tbl[3]  = '{640,  ev(0,   0, 0, 1, 1, 0, 0, 0)};
        tbl[4]  = '{655,  ev(0,   0, 0, 1, 1, 0, 0, 0)};
        tbl[5]  = '{656,  ev(0,   0, 0, 0, 1, 0, 0, 0)};
        tbl[6]  = '{751,  ev(0,   0, 0, 0, 1, 0, 0, 0)};
        tbl[7]  = '{752,  ev(0,   0, 0, 1, 1, 0, 0, 0)};
        tbl[8]  = '{799,  ev(0,   0, 0, 1, 1, 0, 0, 0)};
        tbl[9]  = '{800,  ev(0,   1, 1, 1, 1, 1, 0, 0)};
        tbl[10] = '{805,  ev(5,   1, 1, 1, 1, 0, 0, 0)};
        tbl[11] = '{1700, ev(100, 2, 1, 1, 1, 0, 0, 0)};

        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("big_in_reset", b_act, RST_EXP);
        @(negedge clk);
        #2 rst_n = 1'b1;

        ti = 0; last_ls = 0; b_vcnt = 0; b_hscnt = 0; b_hsfirst = -1; b_fscnt = 0;
        s_fsn = 0; s_last = 0; s_vcnt = 0; s_vslo = 0; s_hslo = 0;
        s_maxx = 0; s_maxy = 0; s_bad = 0;
        for (int cyc = 0; cyc < N; cyc++) begin
            @(posedge clk);
            #1;
            if (ti < NT && tbl[ti].cyc == cyc) begin
                chk($sformatf("big_vec_cyc%0d", cyc), b_act, tbl[ti].exp);
                ti++;
            end
            if (cyc < 800) begin
                if (b_v) b_vcnt++;
                if (!b_hs) begin
                    b_hscnt++;
                    if (b_hsfirst < 0) b_hsfirst = cyc;
                end
            end
            if (cyc == 800) begin
                chk("big_line_valid_cnt", b_vcnt, 640);
                chk("big_hs_low_cnt", b_hscnt, 96);
                chk("big_hs_first", b_hsfirst, 656);
            end
            if (b_ls && cyc > 0 && cyc <= 1700) begin
                chk("big_ls_period", cyc - last_ls, 800);
                last_ls = cyc;
            end
            if (b_fs) b_fscnt++;

            if (s_fs) begin
                if (s_fsn == 2) begin
                    chk("sm_frame_valid_cnt", s_vcnt, 32);
                    chk("sm_frame_vs_low", s_vslo, 12);
                    chk("sm_frame_hs_low", s_hslo, 14);
                    chk("sm_max_x", s_maxx, 7);
                    chk("sm_max_y", s_maxy, 3);
                    chk("sm_xy_zero_blank", s_bad, 0);
                end
                if (s_fsn > 0) chk("sm_fs_period", cyc - s_last, 84);
                if (s_fsn == 255) chk("sm_fc_255", s_fc, 255);
                if (s_fsn == 256) chk("sm_fc_wrap0", s_fc, 0);
                s_last = cyc;
                s_fsn++;
            end
            if (s_fsn == 2) begin
                if (s_v) begin
                    s_vcnt++;
                    if (s_x > s_maxx) s_maxx = s_x;
                    if (s_y > s_maxy) s_maxy = s_y;
                end else if (s_x != 0 || s_y != 0) begin
                    s_bad++;
                end
                if (!s_vs) s_vslo++;
                if (!s_hs) s_hslo++;
            end
        end
        chk("big_single_fs", b_fscnt, 1);
        chk("sm_fs_total", s_fsn, 258);

        // Asynchronous reset in the middle of a frame, between clock edges.
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk);
            #1;
            if (s_v && s_x == 5 && s_y == 2) found = 1;
        end
        chk("midreset_reach", found, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("sm_async_reset", s_act, RST_EXP);
        chk("big_async_reset", b_act, RST_EXP);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("sm_restart", s_act, ev(0, 0, 1, 1, 1, 1, 1, 0));
        chk("big_restart", b_act, ev(0, 0, 1, 1, 1, 1, 1, 0));
        repeat (200) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel-timing generator sitting directly upstream of the pixel-colour stage.
- Produces pixel coordinates X/Y, the active-video qualifier `valid`, and the sync pulses VGA_HS/VGA_VS that drive the connector.
- Also produces frame/line strobes and a frame counter for later animation logic.
- Defaults target 640x480@60 Hz with a 25 MHz VGA_CLK.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of VGA_HS (0 = active-low)
- VS_POL, 0, asserted level of VGA_VS

Ports:
- VGA_CLK  in  1  pixel clock
- RST_N  in  1  reset, asynchronous assert, active-low
- X  out  10  pixel column; 0 outside active region
- Y  out  10  pixel row; 0 outside active region
- valid  out  1  1 when current pixel is inside the active area
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- line_start  out  1  one-cycle pulse at h_cnt==0
- frame_start  out  1  one-cycle pulse at h_cnt==0 && v_cnt==0
- frame_cnt  out  8  frames started since reset, wraps 255->0

Behaviour:
- Interface: one clock, VGA_CLK. Reset RST_N is asynchronous and active-low; it asserts asynchronously and all flops respond immediately.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
  - Both must be <= 1024; violation is an elaboration error.
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and increments every clock, wrapping to 0.
  - v_cnt runs 0..V_TOTAL-1 and increments only on the h_cnt wrap, wrapping to 0.
- During reset:
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1.
  - Outputs: X=0, Y=0, valid=0, VGA_HS=~HS_POL, VGA_VS=~VS_POL, line_start=0, frame_start=0, frame_cnt=0.
- First rising edge after RST_N deasserts: counters wrap to (0,0). That same cycle shows valid=1, X=0, Y=0, line_start=1, frame_start=1, frame_cnt=0.
  - frame_cnt increments on every subsequent frame_start.
  - The first frame after reset is frame 0.
- Output registration:
  - Every output is a flop, computed from the next-state counter values.
  - As a result, outputs are cycle-aligned with the counters: zero latency relative to h_cnt/v_cnt, and glitch-free.
- Active region:
  - valid = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - X = h_cnt and Y = v_cnt when valid; otherwise both are 0.
- Horizontal sync:
  - VGA_HS = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (default 656..751), else ~HS_POL.
  - Independent of v_cnt, so it runs during vertical blanking.
- Vertical sync:
  - VGA_VS = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (default 490..491), else ~VS_POL.
  - VS changes only at h_cnt==0.
- Wrap at (H_TOTAL-1, V_TOTAL-1): the next cycle is (0,0). h and v wrap together; frame_start and line_start both pulse.
- Reset mid-frame: all outputs return to reset values asynchronously. After release, the block restarts at (0,0) exactly as from power-up. No partial sync pulse is stretched.
- No input other than clock and reset. Timing is free-running and deterministic.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants (640x480@60 set);
  - derived H_TOTAL/V_TOTAL;
  - the RGB332 field widths shared with the colour stage (R=3, G=3, B=2).
- One sub-module, vga_axis_counter, instantiated twice (horizontal, vertical).
  - Parameters: TOTAL, ACTIVE, SYNC_START, SYNC_END, POL.
  - Inputs: clk, rst_n, step.
  - Outputs: cnt, cnt_next, wrap, active_next, sync_next.
  - Horizontal instance: step=1. Vertical instance: step = horizontal wrap.

Test Plan:
- Reset release: hold RST_N=0 5 clocks, release -> first edge gives X=0, Y=0, valid=1, frame_start=1, line_start=1, HS=1, VS=1.
- Line timing: run one line from h_cnt=0 -> valid high for exactly 640 clocks. HS low for exactly 96 clocks starting at clock 656. line_start period = 800 clocks.
- Frame timing: run 2 frames -> frame_start period = 420000 clocks. VS low during lines 490-491 only (1600 clocks). valid never high on lines 480-524.
- Coordinate range: across a frame, max X=639, max Y=479. X and Y read 0 whenever valid=0. Exactly 307200 valid cycles per frame.
- Counter wrap: run 256 frames (reduced-size parameters H_ACTIVE=8, porches 1/2/1, V_ACTIVE=4, 1/1/1 allowed) -> frame_cnt goes 255 then 0 on next frame_start.
- Mid-frame reset: assert RST_N=0 asynchronously at h=300, v=200 -> outputs go to reset values without a clock edge. After release, restart at (0,0) with frame_cnt=0.
